// File: rtl/m_dm.sv
// M-stage data memory: word/half/byte loads (combinational, extended)
// and byte-lane-merged synchronous stores with async clear.
module m_dm #(
  parameter int          DEPTH_WORDS = 3072,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        exc_align,
  output logic        exc_range
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] off;
  logic [AW-1:0] idx;
  logic [1:0]  b;
  logic        is_h;
  logic        is_b;
  logic        sx;
  logic [31:0] cur;
  logic [7:0]  bt;
  logic [15:0] hw;
  logic [31:0] merged;
  logic        commit;
  logic        unused_bits;

  assign off = addr - ADDR_BASE;
  assign idx = off[AW+1:2];
  assign b   = addr[1:0];
  assign unused_bits = ^{off[31:AW+2], off[1:0]};

  // Reserved op codes fall through to word access
  always_comb begin
    is_h = 1'b0;
    is_b = 1'b0;
    sx   = 1'b0;
    case (op)
      3'b001: begin is_h = 1'b1; sx = 1'b1; end
      3'b010: is_h = 1'b1;
      3'b011: begin is_b = 1'b1; sx = 1'b1; end
      3'b100: is_b = 1'b1;
      default: ;
    endcase
  end

  assign exc_range = (off >= LIMIT);
  assign exc_align = is_h ? b[0] : (!is_b && (b != 2'b00));
  assign commit    = WE && !exc_align && !exc_range;

  assign cur = mem[idx];
  assign hw  = b[1] ? cur[31:16] : cur[15:0];

  always_comb begin
    bt = cur[7:0];
    case (b)
      2'd1: bt = cur[15:8];
      2'd2: bt = cur[23:16];
      2'd3: bt = cur[31:24];
      default: ;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (!exc_align && !exc_range) begin
      if (is_b)
        rdata = {{24{sx & bt[7]}}, bt};
      else if (is_h)
        rdata = {{16{sx & hw[15]}}, hw};
      else
        rdata = cur;
    end
  end

  always_comb begin
    merged = cur;
    if (is_b) begin
      case (b)
        2'd0: merged[7:0]   = wdata[7:0];
        2'd1: merged[15:8]  = wdata[7:0];
        2'd2: merged[23:16] = wdata[7:0];
        default: merged[31:24] = wdata[7:0];
      endcase
    end else if (is_h) begin
      if (b[1])
        merged[31:16] = wdata[15:0];
      else
        merged[15:0] = wdata[15:0];
    end else begin
      merged = wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++)
        mem[i] <= '0;
    end else if (commit) begin
      mem[idx] <= merged;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset && commit)
      $display("%d@%h: *%h <= %h", $time, pc,
               32'({idx, 2'b00}) + ADDR_BASE, merged);
  end
`endif

endmodule

// File: tb/tb_m_dm.sv
// Directed self-checking bench for m_dm: loads, stores,
// lane merging, exceptions and asynchronous reset.
module tb_m_dm;

  logic        clk;
  logic        reset;
  logic        WE;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic [31:0] rdata;
  logic        exc_align;
  logic        exc_range;

  int checks;
  int errors;

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_HU = 3'b010;
  localparam logic [2:0] OP_B  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;

  m_dm dut (
    .clk(clk), .reset(reset), .WE(WE), .op(op), .addr(addr),
    .wdata(wdata), .pc(pc), .rdata(rdata),
    .exc_align(exc_align), .exc_range(exc_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic store(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] d);
    WE = 1'b1; op = o; addr = a; wdata = d; pc = pc + 4;
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  task automatic load(input logic [2:0] o, input logic [31:0] a);
    WE = 1'b0; op = o; addr = a;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; WE = 1'b0; op = OP_W; addr = '0; wdata = '0;
    pc = 32'h0000_1000;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    load(OP_W, 32'h0);
    checks++;
    if (rdata !== 32'h0 || exc_align !== 1'b0 || exc_range !== 1'b0) begin
      errors++;
      $display("FAIL reset_w0: rdata=%h al=%b rg=%b want 0/0/0",
               rdata, exc_align, exc_range);
    end
    load(OP_W, 32'h2FFC);
    checks++;
    if (rdata !== 32'h0 || exc_align !== 1'b0 || exc_range !== 1'b0) begin
      errors++;
      $display("FAIL reset_wtop: rdata=%h al=%b rg=%b want 0/0/0",
               rdata, exc_align, exc_range);
    end
  endtask

  task automatic test_word_byte;
    WE = 1'b1; op = OP_W; addr = 32'h10; wdata = 32'h8765_4321;
    #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL rdw_old: got %h want 00000000", rdata);
    end
    @(posedge clk); #1;
    checks++;
    if (rdata !== 32'h8765_4321) begin
      errors++;
      $display("FAIL rdw_new: got %h want 87654321", rdata);
    end
    WE = 1'b0;
    load(OP_B, 32'h11);
    checks++;
    if (rdata !== 32'h0000_0043) begin
      errors++;
      $display("FAIL lb_11: got %h want 00000043", rdata);
    end
    load(OP_B, 32'h13);
    checks++;
    if (rdata !== 32'hFFFF_FF87) begin
      errors++;
      $display("FAIL lb_13: got %h want ffffff87", rdata);
    end
    load(OP_BU, 32'h13);
    checks++;
    if (rdata !== 32'h0000_0087) begin
      errors++;
      $display("FAIL lbu_13: got %h want 00000087", rdata);
    end
    load(OP_HU, 32'h10);
    checks++;
    if (rdata !== 32'h0000_4321) begin
      errors++;
      $display("FAIL lhu_10: got %h want 00004321", rdata);
    end
  endtask

  task automatic test_half;
    store(OP_H, 32'h12, 32'h1234_BEEF);
    load(OP_W, 32'h10);
    checks++;
    if (rdata !== 32'hBEEF_4321) begin
      errors++;
      $display("FAIL sh_word: got %h want beef4321", rdata);
    end
    load(OP_H, 32'h12);
    checks++;
    if (rdata !== 32'hFFFF_BEEF) begin
      errors++;
      $display("FAIL lh_12: got %h want ffffbeef", rdata);
    end
    load(OP_HU, 32'h12);
    checks++;
    if (rdata !== 32'h0000_BEEF) begin
      errors++;
      $display("FAIL lhu_12: got %h want 0000beef", rdata);
    end
    load(OP_H, 32'h10);
    checks++;
    if (rdata !== 32'h0000_4321) begin
      errors++;
      $display("FAIL lh_10: got %h want 00004321", rdata);
    end
  endtask

  task automatic test_back_to_back;
    store(OP_W, 32'h10, 32'h8765_4321);
    WE = 1'b1; op = OP_B; addr = 32'h10; wdata = 32'h5555_55AA;
    @(posedge clk); #1;
    addr = 32'h11; wdata = 32'h0000_00BB;
    @(posedge clk); #1;
    WE = 1'b0;
    load(OP_W, 32'h10);
    checks++;
    if (rdata !== 32'h8765_BBAA) begin
      errors++;
      $display("FAIL sb_b2b: got %h want 8765bbaa", rdata);
    end
    load(OP_BU, 32'h11);
    checks++;
    if (rdata !== 32'h0000_00BB) begin
      errors++;
      $display("FAIL lbu_11: got %h want 000000bb", rdata);
    end
  endtask

  task automatic test_exceptions;
    WE = 1'b1; op = OP_W; addr = 32'h12; wdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (exc_align !== 1'b1 || exc_range !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL sw_misalign: al=%b rg=%b rd=%h want 1/0/0",
               exc_align, exc_range, rdata);
    end
    @(posedge clk); #1;
    WE = 1'b0;
    load(OP_H, 32'h11);
    checks++;
    if (exc_align !== 1'b1 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL lh_misalign: al=%b rd=%h want 1/0", exc_align, rdata);
    end
    load(OP_W, 32'h10);
    checks++;
    if (rdata !== 32'h8765_BBAA) begin
      errors++;
      $display("FAIL align_nostore: got %h want 8765bbaa", rdata);
    end
    WE = 1'b1; op = OP_W; addr = 32'h3000; wdata = 32'hCAFE_F00D;
    #1;
    checks++;
    if (exc_range !== 1'b1 || exc_align !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL sw_range: rg=%b al=%b rd=%h want 1/0/0",
               exc_range, exc_align, rdata);
    end
    @(posedge clk); #1;
    WE = 1'b0;
    load(OP_W, 32'h0);
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL range_nostore: got %h want 00000000", rdata);
    end
    load(OP_W, 32'h2FFC);
    checks++;
    if (rdata !== 32'h0 || exc_range !== 1'b0) begin
      errors++;
      $display("FAIL top_word: rd=%h rg=%b want 0/0", rdata, exc_range);
    end
    load(3'b101, 32'h10);
    checks++;
    if (rdata !== 32'h8765_BBAA || exc_align !== 1'b0) begin
      errors++;
      $display("FAIL reserved_op: rd=%h al=%b want 8765bbaa/0",
               rdata, exc_align);
    end
    load(3'b110, 32'h11);
    checks++;
    if (exc_align !== 1'b1) begin
      errors++;
      $display("FAIL reserved_align: al=%b want 1", exc_align);
    end
    load(OP_BU, 32'h2FFF);
    checks++;
    if (exc_align !== 1'b0 || exc_range !== 1'b0) begin
      errors++;
      $display("FAIL bu_top: al=%b rg=%b want 0/0", exc_align, exc_range);
    end
  endtask

  task automatic test_reset_midcycle;
    WE = 1'b1; op = OP_W; addr = 32'h10; wdata = 32'h1234_5678;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL async_clear: got %h want 00000000", rdata);
    end
    @(posedge clk); #2;
    WE = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL store_lost: got %h want 00000000", rdata);
    end
    load(OP_HU, 32'h12);
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL store_lost_hi: got %h want 00000000", rdata);
    end
    store(OP_W, 32'h10, 32'h0BAD_F00D);
    load(OP_W, 32'h10);
    checks++;
    if (rdata !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL post_reset_sw: got %h want 0badf00d", rdata);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_word_byte;
    test_half;
    test_back_to_back;
    test_exceptions;
    test_reset_midcycle;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
